mux_sync_launch: RTL and testbench

- Source-domain launcher that sits directly upstream of mux_bit_sync.
- Accepts a WIDTH-bit word through a valid/ready interface and holds it stable on data_hold.
- Drives the ready qualifier that mux_bit_sync synchronizes into the destination domain.
- Runs a 4-phase req/ack handshake against an ack level returned from the destination domain. A word is never changed while the destination may still be sampling it.

---
 rtl/mux_sync_launch.sv | 170 +++++++++++++++++
 tb/tb_mux_sync_launch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sync_launch.sv
`default_nettype none
// ============================================================================
// mux_sync_launch : source-domain 4-phase req/ack launcher feeding mux_bit_sync
// Optional one-entry pending word: define MUX_SYNC_LAUNCH_SKID_EN.   Rev 1.0
// ============================================================================

module synchronize_bit #(
    parameter int NUM_OF_SYNC_FLOPS = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic [NUM_OF_SYNC_FLOPS-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) chain <= '0;
        else       chain <= {chain[NUM_OF_SYNC_FLOPS-2:0], d};
    end

    assign q = chain[NUM_OF_SYNC_FLOPS-1];
endmodule

module mux_sync_launch #(
    parameter int               WIDTH             = 8,
    parameter int               NUM_OF_SYNC_FLOPS = 2,
    parameter logic [WIDTH-1:0] RESET_VAL         = '0
) (
    input  logic             src_clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] data_hold,
    output logic             ready_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             xfer_done
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        RELEASE = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             ready_nxt;
    logic             done_nxt;
    logic             sync_ack;
    logic             accept;

    synchronize_bit #(
        .NUM_OF_SYNC_FLOPS(NUM_OF_SYNC_FLOPS)
    ) u_ack_sync (
        .clk  (src_clk),
        .rstn (rstn),
        .d    (ack_in),
        .q    (sync_ack)
    );

`ifdef MUX_SYNC_LAUNCH_SKID_EN
    logic             pend_valid, pend_valid_nxt;
    logic [WIDTH-1:0] pend_data, pend_data_nxt;

    assign in_ready = !pend_valid && !((state == IDLE) && sync_ack);
`else
    // A stale ack from the previous word must drain before a new request.
    assign in_ready = (state == IDLE) && !sync_ack;
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        data_nxt  = data_hold;
        ready_nxt = ready_out;
        done_nxt  = 1'b0;
`ifdef MUX_SYNC_LAUNCH_SKID_EN
        pend_valid_nxt = pend_valid;
        pend_data_nxt  = pend_data;
        if (accept && (state != IDLE)) begin
            pend_valid_nxt = 1'b1;
            pend_data_nxt  = in_data;
        end
`endif
        case (state)
            IDLE: begin
                ready_nxt = 1'b0;
`ifdef MUX_SYNC_LAUNCH_SKID_EN
                // A word parked during the completion cycle launches from here.
                if (pend_valid) begin
                    if (!sync_ack) begin
                        data_nxt       = pend_data;
                        pend_valid_nxt = 1'b0;
                        ready_nxt      = 1'b1;
                        state_nxt      = REQ;
                    end
                end else if (accept) begin
                    data_nxt  = in_data;
                    ready_nxt = 1'b1;
                    state_nxt = REQ;
                end
`else
                if (accept) begin
                    data_nxt  = in_data;
                    ready_nxt = 1'b1;
                    state_nxt = REQ;
                end
`endif
            end
            REQ: begin
                ready_nxt = 1'b1;
                if (sync_ack) begin
                    ready_nxt = 1'b0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                ready_nxt = 1'b0;
                if (!sync_ack) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
`ifdef MUX_SYNC_LAUNCH_SKID_EN
                    if (pend_valid) begin
                        data_nxt       = pend_data;
                        pend_valid_nxt = 1'b0;
                        ready_nxt      = 1'b1;
                        state_nxt      = REQ;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge src_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            data_hold <= RESET_VAL;
            ready_out <= 1'b0;
            xfer_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_hold <= data_nxt;
            ready_out <= ready_nxt;
            xfer_done <= done_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

`ifdef MUX_SYNC_LAUNCH_SKID_EN
    always_ff @(posedge src_clk or negedge rstn) begin
        if (!rstn) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            pend_valid <= pend_valid_nxt;
            pend_data  <= pend_data_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_sync_launch.sv
`default_nettype none
// Testbench for mux_sync_launch: vector table, hand-written corner sequences
// and a randomized run against a protocol-level reference model.

module tb_mux_sync_launch;
    localparam int         W  = 8;
    localparam int         NS = 2;
    localparam logic [W-1:0] RV = 8'h5A;

    logic         clk      = 1'b0;
    logic         rstn     = 1'b0;
    logic         in_valid = 1'b0;
    logic         ack_in   = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_ready;
    logic [W-1:0] data_hold;
    logic         ready_out;
    logic         busy;
    logic         xfer_done;

    int checks   = 0;
    int failures = 0;

    mux_sync_launch #(
        .WIDTH             (W),
        .NUM_OF_SYNC_FLOPS (NS),
        .RESET_VAL         (RV)
    ) dut (
        .src_clk   (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .data_hold (data_hold),
        .ready_out (ready_out),
        .ack_in    (ack_in),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (handshake phases) ----------------
    // phase 0: free, 1: request raised waiting for ack, 2: waiting for ack to drop
    int           m_phase;
    logic [W-1:0] m_hold, m_pend;
    bit           m_ready, m_done, m_pv;
    bit           ack_hist[$];   // last NS ack samples, oldest first

    function automatic void model_reset();
        m_phase = 0; m_hold = RV; m_ready = 0; m_done = 0; m_pv = 0; m_pend = '0;
        ack_hist.delete();
        repeat (NS) ack_hist.push_back(1'b0);
    endfunction

    function automatic bit model_in_ready();
`ifdef MUX_SYNC_LAUNCH_SKID_EN
        return !m_pv && !(m_phase == 0 && ack_hist[0]);
`else
        return (m_phase == 0) && !ack_hist[0];
`endif
    endfunction

    function automatic void model_launch(input logic [W-1:0] word);
        m_hold = word; m_ready = 1; m_phase = 1;
    endfunction

    function automatic void model_step(input bit v, input logic [W-1:0] d, input bit a);
        bit s   = ack_hist[0];
        bit acc = v && model_in_ready();
        bit pv0 = m_pv;
        m_done = 0;
        if (m_phase == 0) begin
            if (pv0) begin
                if (!s) begin model_launch(m_pend); m_pv = 0; end
            end else if (acc) model_launch(d);
        end else begin
`ifdef MUX_SYNC_LAUNCH_SKID_EN
            if (acc) begin m_pend = d; m_pv = 1; end
`endif
            if (m_phase == 1 && s) begin
                m_ready = 0; m_phase = 2;
            end else if (m_phase == 2 && !s) begin
                m_done = 1;
                if (pv0) begin model_launch(m_pend); m_pv = 0; end
                else m_phase = 0;
            end
        end
        ack_hist.push_back(a);
        void'(ack_hist.pop_front());
    endfunction

    task automatic compare_model();
        chk("rnd_ready_out", ready_out, m_ready);
        chk("rnd_data_hold", data_hold, m_hold);
        chk("rnd_busy",      busy,      m_phase != 0);
        chk("rnd_xfer_done", xfer_done, m_done);
        chk("rnd_in_ready",  in_ready,  model_in_ready());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           a;
        bit           e_ready;
        logic [W-1:0] e_hold;
        bit           e_busy;
        bit           e_done;
        bit           e_irdy;
    } vec_t;

    vec_t vecs[14];

    task automatic ack_cycle(input int hi, input int lo);
        ack_in = 1'b1; repeat (hi) tick();
        ack_in = 1'b0; repeat (lo) tick();
    endtask

    initial begin
        vecs[0]  = '{1, 8'hA5, 0, 1, 8'hA5, 1, 0, 0};
        vecs[1]  = '{0, 8'h00, 0, 1, 8'hA5, 1, 0, 0};
        vecs[2]  = '{0, 8'h00, 0, 1, 8'hA5, 1, 0, 0};
        vecs[3]  = '{0, 8'h00, 0, 1, 8'hA5, 1, 0, 0};
        vecs[4]  = '{0, 8'h00, 1, 1, 8'hA5, 1, 0, 0};
        vecs[5]  = '{0, 8'h00, 1, 1, 8'hA5, 1, 0, 0};
        vecs[6]  = '{0, 8'h00, 1, 0, 8'hA5, 1, 0, 0};
        vecs[7]  = '{0, 8'h00, 1, 0, 8'hA5, 1, 0, 0};
        vecs[8]  = '{0, 8'h00, 1, 0, 8'hA5, 1, 0, 0};
        vecs[9]  = '{0, 8'h00, 1, 0, 8'hA5, 1, 0, 0};
        vecs[10] = '{0, 8'h00, 0, 0, 8'hA5, 1, 0, 0};
        vecs[11] = '{0, 8'h00, 0, 0, 8'hA5, 1, 0, 0};
        vecs[12] = '{0, 8'h00, 0, 0, 8'hA5, 0, 1, 1};
        vecs[13] = '{0, 8'h00, 0, 0, 8'hA5, 0, 0, 1};

        // reset state
        #1;
        chk("in_ready_during_reset", in_ready, 1'b1);
        chk("ready_out_during_reset", ready_out, 1'b0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("reset_data_hold", data_hold, RV);
        chk("reset_ready_out", ready_out, 1'b0);
        chk("reset_in_ready",  in_ready,  1'b1);
        chk("reset_busy",      busy,      1'b0);
        chk("reset_xfer_done", xfer_done, 1'b0);

        // full handshake of 0xA5 from the table
        for (int i = 0; i < 14; i++) begin
            in_valid = vecs[i].v; in_data = vecs[i].d; ack_in = vecs[i].a;
            tick();
            chk($sformatf("vec%0d_ready_out", i), ready_out, vecs[i].e_ready);
            chk($sformatf("vec%0d_data_hold", i), data_hold, vecs[i].e_hold);
            chk($sformatf("vec%0d_busy", i),      busy,      vecs[i].e_busy);
            chk($sformatf("vec%0d_xfer_done", i), xfer_done, vecs[i].e_done);
            chk($sformatf("vec%0d_in_ready", i),  in_ready,  vecs[i].e_irdy);
        end

        // stale ack blocks accept
        ack_in = 1'b1; in_valid = 1'b0;
        repeat (2) tick();
        chk("stale_ack_in_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_data = 8'h77;
        repeat (3) tick();
        chk("stale_ack_busy",      busy,      1'b0);
        chk("stale_ack_ready_out", ready_out, 1'b0);
        chk("stale_ack_data_hold", data_hold, 8'hA5);
        in_valid = 1'b0; ack_in = 1'b0;
        tick();
        chk("ack_drop_1edge_in_ready", in_ready, 1'b0);
        tick();
        chk("ack_drop_2edge_in_ready", in_ready, 1'b1);

`ifndef MUX_SYNC_LAUNCH_SKID_EN
        // input churn while busy is ignored
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        chk("churn_accept_hold", data_hold, 8'h3C);
        in_data = 8'hC3; ack_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("churn_hold_frozen", data_hold, 8'h3C);
            chk("churn_in_ready",    in_ready,  1'b0);
        end
        ack_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("churn_hold_release", data_hold, 8'h3C);
        end
        tick();
        chk("churn_done",       xfer_done, 1'b1);
        chk("churn_done_hold",  data_hold, 8'h3C);
        chk("churn_idle_ready", in_ready,  1'b1);
        tick();
        chk("churn_second_accept", data_hold, 8'hC3);
        chk("churn_second_req",    ready_out, 1'b1);
        in_valid = 1'b0;
        ack_cycle(3, 3);
        chk("churn_second_done", xfer_done, 1'b1);
        tick();
`else
        // back-to-back words through the pending register
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        chk("skid_first_hold", data_hold, 8'h11);
        in_data = 8'h22;
        tick();
        chk("skid_pending_full_in_ready", in_ready,  1'b0);
        chk("skid_hold_still_first",      data_hold, 8'h11);
        in_valid = 1'b0;
        ack_cycle(3, 3);
        chk("skid_done1",      xfer_done, 1'b1);
        chk("skid_next_hold",  data_hold, 8'h22);
        chk("skid_next_ready", ready_out, 1'b1);
        chk("skid_next_busy",  busy,      1'b1);
        ack_cycle(3, 3);
        chk("skid_done2",      xfer_done, 1'b1);
        chk("skid_done2_hold", data_hold, 8'h22);
        chk("skid_done2_busy", busy,      1'b0);
        tick();
`endif

        // asynchronous reset while a request is raised
        in_valid = 1'b1; in_data = 8'h96;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_ready", ready_out, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_ready_out", ready_out, 1'b0);
        chk("async_rst_data_hold", data_hold, RV);
        chk("async_rst_busy",      busy,      1'b0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'hE7;
        tick();
        in_valid = 1'b0;
        chk("post_rst_accept_hold",  data_hold, 8'hE7);
        chk("post_rst_accept_ready", ready_out, 1'b1);
        ack_cycle(3, 3);
        chk("post_rst_done", xfer_done, 1'b1);

        // randomized run against the reference model
        rstn = 1'b0; ack_in = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            bit           v = 1'($urandom_range(0, 1));
            logic [W-1:0] d = W'($urandom);
            bit           a = ack_in;
            if ($urandom_range(0, 3) == 0) a = ready_out;
            if ($urandom_range(0, 31) == 0) a = ~a;
            in_valid = v; in_data = d; ack_in = a;
            tick();
            model_step(v, d, a);
            compare_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
